// File: rtl/reg_file_pkg.sv
// Shared CPU package: register file geometry and the hard-wired zero register address.
package reg_file_pkg;

  localparam int unsigned RF_AW        = 5;
  localparam int unsigned RF_DW        = 32;
  localparam int unsigned RF_ZERO_ADDR = 0;

endpackage : reg_file_pkg

// File: rtl/reg_file_if.sv
// Register file bus: two read ports with busy flags, one write port, one scoreboard set port.
interface reg_file_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);

  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [DW-1:0] qa;
  logic [DW-1:0] qb;
  logic          ba;
  logic          bb;
  logic          we;
  logic [AW-1:0] wr;
  logic [DW-1:0] d;
  logic          set;
  logic [AW-1:0] sr;

  modport master (
    output ra, rb, we, wr, d, set, sr,
    input  qa, qb, ba, bb
  );

  modport slave (
    input  ra, rb, we, wr, d, set, sr,
    output qa, qb, ba, bb
  );

endinterface : reg_file_if

// File: rtl/reg_file_rdport.sv
// One combinational read port: address -> data and busy flag.
// With REG_FILE_BYPASS_EN defined, a same-cycle write to the read address is forwarded.
module reg_file_rdport
  import reg_file_pkg::*;
#(
  parameter int unsigned AW = RF_AW,
  parameter int unsigned DW = RF_DW
) (
`ifdef REG_FILE_BYPASS_EN
  input  logic                         we,
  input  logic [AW-1:0]                wr,
  input  logic [DW-1:0]                d,
  input  logic                         set,
  input  logic [AW-1:0]                sr,
`endif
  input  logic [AW-1:0]                addr,
  input  logic [(2**AW)-1:0][DW-1:0]   regs,
  input  logic [(2**AW)-1:0]           busy,
  output logic [DW-1:0]                q,
  output logic                         b
);

  // Select stored data/busy; register zero always reads as idle zero.
  always_comb begin
    q = regs[addr];
    b = busy[addr];
    if (addr == AW'(RF_ZERO_ADDR)) begin
      q = '0;
      b = 1'b0;
    end
`ifdef REG_FILE_BYPASS_EN
    if (we && (wr != AW'(RF_ZERO_ADDR)) && (wr == addr)) begin
      q = d;
      b = set && (sr == addr);
    end
`endif
  end

endmodule : reg_file_rdport

// File: rtl/reg_file.sv
// Two-read/one-write register file with a per-register busy scoreboard.
// Optional feature macro: REG_FILE_BYPASS_EN (write-to-read forwarding).
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DW = RF_DW,
  parameter int unsigned AW = RF_AW
) (
  input logic       clk,
  input logic       clrn,
  reg_file_if.slave bus
);

  localparam int unsigned NREG = 2**AW;

  logic [NREG-1:0][DW-1:0] regs;
  logic [NREG-1:0]         busy;
  logic                    wr_hit_c;
  logic                    set_hit_c;

  assign wr_hit_c  = bus.we  && (bus.wr != AW'(RF_ZERO_ADDR));
  assign set_hit_c = bus.set && (bus.sr != AW'(RF_ZERO_ADDR));

  // Register storage; address zero is never written.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      regs <= '0;
    end else if (wr_hit_c) begin
      regs[bus.wr] <= bus.d;
    end
  end

  // Scoreboard: write clears, set marks pending; set is applied last so a new producer wins.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      busy <= '0;
    end else begin
      if (wr_hit_c) begin
        busy[bus.wr] <= 1'b0;
      end
      if (set_hit_c) begin
        busy[bus.sr] <= 1'b1;
      end
    end
  end

  reg_file_rdport #(.AW(AW), .DW(DW)) u_port_a (
`ifdef REG_FILE_BYPASS_EN
    .we   (bus.we && clrn),
    .wr   (bus.wr),
    .d    (bus.d),
    .set  (bus.set),
    .sr   (bus.sr),
`endif
    .addr (bus.ra),
    .regs (regs),
    .busy (busy),
    .q    (bus.qa),
    .b    (bus.ba)
  );

  reg_file_rdport #(.AW(AW), .DW(DW)) u_port_b (
`ifdef REG_FILE_BYPASS_EN
    .we   (bus.we && clrn),
    .wr   (bus.wr),
    .d    (bus.d),
    .set  (bus.set),
    .sr   (bus.sr),
`endif
    .addr (bus.rb),
    .regs (regs),
    .busy (busy),
    .q    (bus.qb),
    .b    (bus.bb)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file against an array-based reference model.
module tb_reg_file;

  logic clk;
  logic clrn;
  int   checks;
  int   failures;

  logic [31:0] mdl_regs [32];
  bit          mdl_busy [32];

  reg_file_if #(.AW(5), .DW(32)) bus ();

  reg_file #(.DW(32), .AW(5)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void mdl_clear();
    for (int i = 0; i < 32; i++) begin
      mdl_regs[i] = 32'h0;
      mdl_busy[i] = 1'b0;
    end
  endfunction

  // Expected read data for an address under the current inputs.
  function automatic logic [31:0] exp_q(input logic [4:0] a);
    if (a == 5'd0 || !clrn) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
    if (bus.we && bus.wr != 5'd0 && bus.wr == a) return bus.d;
`endif
    return mdl_regs[a];
  endfunction

  // Expected busy flag for an address under the current inputs.
  function automatic logic exp_b(input logic [4:0] a);
    if (a == 5'd0 || !clrn) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if (bus.we && bus.wr != 5'd0 && bus.wr == a) return bus.set && (bus.sr == a);
`endif
    return mdl_busy[a];
  endfunction

  // Advance one clock, applying the architectural effect of the current inputs to the model.
  task automatic tick();
    if (clrn) begin
      if (bus.we && bus.wr != 5'd0) begin
        mdl_regs[bus.wr] = bus.d;
        mdl_busy[bus.wr] = 1'b0;
      end
      if (bus.set && bus.sr != 5'd0) mdl_busy[bus.sr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we  = 1'b0;
    bus.set = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] v);
    bus.we = 1'b1; bus.wr = a; bus.d = v;
    tick();
    idle();
  endtask

  task automatic test_reset();
    #2;
    bus.ra = 5'($urandom_range(0, 31));
    bus.rb = 5'($urandom_range(0, 31));
    #1;
    checks++;
    if (bus.qa !== 32'h0 || bus.ba !== 1'b0) begin
      failures++;
      $display("FAIL reset_initial: qa=%h ba=%b required qa=0 ba=0", bus.qa, bus.ba);
    end
    clrn = 1'b1;
    tick();
    do_write(5'd5, 32'hDEADBEEF);
    bus.set = 1'b1; bus.sr = 5'd6;
    tick();
    idle();
    bus.ra = 5'd5; bus.rb = 5'd6;
    #1;
    checks++;
    if (bus.qa !== 32'hDEADBEEF || bus.bb !== 1'b1) begin
      failures++;
      $display("FAIL reset_prewrite: qa=%h bb=%b required qa=deadbeef bb=1", bus.qa, bus.bb);
    end
    clrn = 1'b0;
    mdl_clear();
    #1;
    checks++;
    if (bus.qa !== 32'h0 || bus.bb !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: qa=%h bb=%b required qa=0 bb=0", bus.qa, bus.bb);
    end
    bus.we = 1'b1; bus.wr = 5'd5; bus.d = 32'h13572468;
    bus.set = 1'b1; bus.sr = 5'd5;
    #1;
    checks++;
    if (bus.qa !== 32'h0 || bus.ba !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold_comb: qa=%h ba=%b required qa=0 ba=0", bus.qa, bus.ba);
    end
    tick();
    idle();
    #2;
    clrn = 1'b1;
    #1;
    checks++;
    if (bus.qa !== 32'h0 || bus.ba !== 1'b0) begin
      failures++;
      $display("FAIL reset_ignored_ops: qa=%h ba=%b required qa=0 ba=0", bus.qa, bus.ba);
    end
    tick();
  endtask

  task automatic test_write_read();
    do_write(5'd7, 32'h12345678);
    bus.ra = 5'd7; bus.rb = 5'd0;
    #1;
    checks++;
    if (bus.qa !== 32'h12345678) begin
      failures++;
      $display("FAIL write_read_qa: got %h required 12345678", bus.qa);
    end
    checks++;
    if (bus.qb !== 32'h0) begin
      failures++;
      $display("FAIL write_read_qb0: got %h required 0", bus.qb);
    end
  endtask

  task automatic test_zero_reg();
    do_write(5'd0, 32'hFFFFFFFF);
    bus.set = 1'b1; bus.sr = 5'd0;
    tick();
    idle();
    bus.ra = 5'd0; bus.rb = 5'd0;
    #1;
    checks++;
    if (bus.qa !== 32'h0 || bus.ba !== 1'b0 || bus.bb !== 1'b0) begin
      failures++;
      $display("FAIL zero_reg: qa=%h ba=%b bb=%b required 0 0 0", bus.qa, bus.ba, bus.bb);
    end
  endtask

  task automatic test_scoreboard();
    bus.set = 1'b1; bus.sr = 5'd9;
    tick();
    idle();
    bus.ra = 5'd9;
    #1;
    checks++;
    if (bus.ba !== 1'b1) begin
      failures++;
      $display("FAIL sb_set: ba=%b required 1", bus.ba);
    end
    do_write(5'd9, 32'h00000099);
    #1;
    checks++;
    if (bus.ba !== 1'b0 || bus.qa !== 32'h00000099) begin
      failures++;
      $display("FAIL sb_clear: ba=%b qa=%h required 0 00000099", bus.ba, bus.qa);
    end
    bus.we = 1'b1; bus.wr = 5'd9; bus.d = 32'hCAFE0009;
    bus.set = 1'b1; bus.sr = 5'd9;
    tick();
    idle();
    #1;
    checks++;
    if (bus.ba !== 1'b1 || bus.qa !== 32'hCAFE0009) begin
      failures++;
      $display("FAIL sb_set_and_write: ba=%b qa=%h required 1 cafe0009", bus.ba, bus.qa);
    end
    bus.we = 1'b1; bus.wr = 5'd9; bus.d = 32'h0000AAAA;
    bus.set = 1'b1; bus.sr = 5'd10;
    tick();
    idle();
    bus.rb = 5'd10;
    #1;
    checks++;
    if (bus.ba !== 1'b0 || bus.bb !== 1'b1 || bus.qa !== 32'h0000AAAA) begin
      failures++;
      $display("FAIL sb_independent: ba=%b bb=%b qa=%h required 0 1 0000aaaa", bus.ba, bus.bb, bus.qa);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    do_write(5'd3, 32'h11112222);
    bus.we = 1'b1; bus.wr = 5'd3; bus.d = 32'hA5A5A5A5;
    bus.ra = 5'd3; bus.rb = 5'd3;
`ifdef REG_FILE_BYPASS_EN
    want = 32'hA5A5A5A5;
`else
    want = 32'h11112222;
`endif
    #1;
    checks++;
    if (bus.qa !== want || bus.qb !== want) begin
      failures++;
      $display("FAIL bypass_same_cycle: qa=%h qb=%h required %h", bus.qa, bus.qb, want);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.qa !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL bypass_after_edge: qa=%h required a5a5a5a5", bus.qa);
    end
  endtask

  task automatic test_dual_port();
    do_write(5'd12, 32'h00000C0C);
    bus.ra = 5'd12; bus.rb = 5'd12;
    #1;
    checks++;
    if (bus.qa !== 32'h00000C0C || bus.qb !== 32'h00000C0C || bus.ba !== 1'b0 || bus.bb !== 1'b0) begin
      failures++;
      $display("FAIL dual_port_data: qa=%h qb=%h ba=%b bb=%b required 00000c0c 00000c0c 0 0",
               bus.qa, bus.qb, bus.ba, bus.bb);
    end
    bus.set = 1'b1; bus.sr = 5'd12;
    tick();
    idle();
    #1;
    checks++;
    if (bus.ba !== 1'b1 || bus.bb !== 1'b1) begin
      failures++;
      $display("FAIL dual_port_busy: ba=%b bb=%b required 1 1", bus.ba, bus.bb);
    end
  endtask

  // Random traffic concentrated on a few addresses to provoke collisions.
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.we  = 1'($urandom_range(0, 1));
      bus.set = 1'($urandom_range(0, 2) == 0);
      bus.wr  = 5'($urandom_range(0, 7));
      bus.sr  = 5'($urandom_range(0, 7));
      bus.ra  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      bus.rb  = 5'($urandom_range(0, 7));
      bus.d   = $urandom();
      #1;
      checks++;
      if (bus.qa !== exp_q(bus.ra) || bus.ba !== exp_b(bus.ra)) begin
        failures++;
        $display("FAIL random_port_a[%0d]: ra=%0d qa=%h ba=%b required %h %b",
                 n, bus.ra, bus.qa, bus.ba, exp_q(bus.ra), exp_b(bus.ra));
      end
      checks++;
      if (bus.qb !== exp_q(bus.rb) || bus.bb !== exp_b(bus.rb)) begin
        failures++;
        $display("FAIL random_port_b[%0d]: rb=%0d qb=%h bb=%b required %h %b",
                 n, bus.rb, bus.qb, bus.bb, exp_q(bus.rb), exp_b(bus.rb));
      end
      tick();
    end
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mdl_clear();
    clrn    = 1'b0;
    bus.we  = 1'b0;
    bus.set = 1'b0;
    bus.wr  = 5'd0;
    bus.sr  = 5'd0;
    bus.d   = 32'h0;
    bus.ra  = 5'd0;
    bus.rb  = 5'd0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_bypass();
    test_dual_port();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_file

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DW, default 32, data width of each register.
REQ-002 Parameter AW, default 5, register address width; 2**AW registers, matching the 5-bit write-register select feeding this block.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Clrn  input  1  reset, asynchronous, active-low.
REQ-005 Ra  input  AW  read port A address.
REQ-006 Rb  input  AW  read port B address.
REQ-007 Qa  output  DW  read port A data.
REQ-008 Qb  output  DW  read port B data.
REQ-009 We  input  1  write enable.
REQ-010 Wr  input  AW  write address, driven by the upstream 5-bit destination mux.
REQ-011 D  input  DW  write data.
REQ-012 Set  input  1  scoreboard set: mark register Sr as pending a write.
REQ-013 Sr  input  AW  scoreboard set address.
REQ-014 Ba  output  1  register Ra is pending (busy).
REQ-015 Bb  output  1  register Rb is pending (busy).

Function
REQ-016 Reads SHALL be combinational: Qa = reg[Ra], Qb = reg[Rb], with zero-cycle latency.
REQ-017 Register 0 SHALL read as 0 at all times; writes to address 0 are discarded.
REQ-018 When We=1 and Wr!=0, reg[Wr] SHALL take D on the rising Clk edge.
REQ-019 Scoreboard: one busy bit per register; Set=1 with Sr!=0 sets busy[Sr] on the rising edge.
REQ-020 A write (We=1, Wr!=0) SHALL clear busy[Wr] on the same edge.
REQ-021 Set and write to the same address in the same cycle: the busy bit SHALL end set (new producer wins); the data write still occurs.
REQ-022 Set and write to different addresses in the same cycle SHALL both take effect independently.
REQ-023 busy[0] SHALL always read 0; Ba = busy[Ra], Bb = busy[Rb], combinational.
REQ-024 Ra == Rb is legal; both ports SHALL return identical data and busy values.

Reset
REQ-025 Clrn=0 SHALL immediately, without waiting for Clk, clear all registers to 0 and all busy bits to 0; Qa=Qb=0 and Ba=Bb=0 while reset is asserted.
REQ-026 Writes and Set pulses coincident with Clrn=0 SHALL be ignored; normal operation resumes on the first rising edge after Clrn deasserts.

Configuration
REQ-027 Macro REG_FILE_BYPASS_EN: when defined, if We=1 and Wr!=0 and Wr==Ra (or Rb), Qa (or Qb) SHALL return D in the same cycle and Ba (or Bb) SHALL read 0 unless Set also targets that address.
REQ-028 Without REG_FILE_BYPASS_EN, reads SHALL return stored contents only; the written value is visible the cycle after the edge.

Structure
REQ-029 The shared CPU package SHALL hold AW, DW and the constant for the zero-register address.
REQ-030 Storage and the scoreboard SHALL be in this module; one sub-module, reg_file_rdport (address -> data/busy, including bypass logic), SHALL be instantiated twice for ports A and B.

Verification
REQ-031 Reset: drive Clrn=0 mid-run after writing reg5=0xDEADBEEF -> Qa at Ra=5 reads 0 immediately, before any Clk edge.
REQ-032 Write/read: We=1, Wr=7, D=0x12345678, one edge -> Ra=7 gives Qa=0x12345678; Rb=0 gives Qb=0.
REQ-033 Zero register: We=1, Wr=0, D=0xFFFFFFFF -> Qa at Ra=0 stays 0; Set with Sr=0 leaves Ba=0.
REQ-034 Scoreboard: Set with Sr=9 -> Ba=1 at Ra=9; a later write to 9 clears Ba; a same-cycle Set and write to 9 leaves Ba=1 with reg9 updated.
REQ-035 Bypass (macro defined): We=1, Wr=3, D=0xA5A5A5A5, Ra=3 in the same cycle -> Qa=0xA5A5A5A5 before the edge; macro undefined -> old reg3 value.
REQ-036 Dual port: Ra=Rb=12 after writing 0x00000C0C -> Qa=Qb=0x00000C0C, Ba=Bb.
